// File: rtl/mem_copy_engine_if.sv
// Host/memory-facing bundle of the copy engine: copy request, status and the data-memory bus.
// The engine attaches through the slave modport; the host side (request + memory) uses master.
interface mem_copy_engine_if #(
   parameter int AW = 8,
   parameter int DW = 8
) ();
   logic          Start;
   logic [AW-1:0] SrcAddr;
   logic [AW-1:0] DstAddr;
   logic [AW-1:0] Len;
   logic          Busy;
   logic          Done;
   logic [AW-1:0] DataAddress;
   logic          ReadMem;
   logic          WriteMem;
   logic [DW-1:0] DataIn;
   logic [DW-1:0] DataOut;

   modport slave (
      input  Start, SrcAddr, DstAddr, Len, DataOut,
      output Busy, Done, DataAddress, ReadMem, WriteMem, DataIn
   );

   modport master (
      output Start, SrcAddr, DstAddr, Len, DataOut,
      input  Busy, Done, DataAddress, ReadMem, WriteMem, DataIn
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-by-byte memory copy: one READ then one WRITE cycle per byte, Done pulse 2*Len+1 cycles after Start.
// No backpressure: the memory is assumed to answer reads combinationally and commit writes every edge.
module mem_copy_engine #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input logic              CLK,
   input logic              RST_N,
   mem_copy_engine_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

   state_t        state;
   state_t        stateNext;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW-1:0] len;
   logic [AW-1:0] idx;
   logic [AW-1:0] idxInc;
   logic [DW-1:0] buffer;

   logic          busy;
   logic          done;
   logic          readMem;
   logic          writeMem;
   logic [AW-1:0] dataAddress;
   logic [DW-1:0] dataIn;

   assign idxInc = idx + {{(AW-1){1'b0}}, 1'b1};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         src    <= '0;
         dst    <= '0;
         len    <= '0;
         idx    <= '0;
         buffer <= '0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               // Operands are frozen here so later input changes cannot disturb the copy.
               if (bus.Start && (bus.Len != '0)) begin
                  src <= bus.SrcAddr;
                  dst <= bus.DstAddr;
                  len <= bus.Len;
                  idx <= '0;
               end
            end
            READ:    buffer <= bus.DataOut;
            WRITE:   idx    <= idxInc;
            default: ;
         endcase
      end
   end

   always_comb begin
      stateNext   = state;
      busy        = 1'b0;
      done        = 1'b0;
      readMem     = 1'b0;
      writeMem    = 1'b0;
      dataAddress = '0;
      dataIn      = '0;
      case (state)
         IDLE: begin
            if (bus.Start) begin
               stateNext = (bus.Len == '0) ? FIN : READ;
            end
         end
         READ: begin
            busy        = 1'b1;
            readMem     = 1'b1;
            dataAddress = src + idx;
            stateNext   = WRITE;
         end
         WRITE: begin
            busy        = 1'b1;
            writeMem    = 1'b1;
            dataAddress = dst + idx;
            dataIn      = buffer;
            stateNext   = (idxInc == len) ? FIN : READ;
         end
         FIN: begin
            // Start is deliberately not looked at here; the next IDLE cycle may pick it up.
            busy      = 1'b1;
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.Busy        = busy;
   assign bus.Done        = done;
   assign bus.ReadMem     = readMem;
   assign bus.WriteMem    = writeMem;
   assign bus.DataAddress = dataAddress;
   assign bus.DataIn      = dataIn;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning the data-memory address width in bits.
REQ-002 The block SHALL have parameter DW, default 8, meaning the data-memory word width in bits.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  copy request; sampled only in IDLE.
REQ-006 SrcAddr  input  AW  first source address; captured with Start.
REQ-007 DstAddr  input  AW  first destination address; captured with Start.
REQ-008 Len  input  AW  byte count, 0..255; captured with Start.
REQ-009 Busy  output  1  high while a copy is in progress.
REQ-010 Done  output  1  single-cycle completion pulse.
REQ-011 DataAddress  output  AW  address driven to the data memory.
REQ-012 ReadMem  output  1  memory read enable.
REQ-013 WriteMem  output  1  memory write enable; the memory commits on the rising edge of CLK.
REQ-014 DataIn  output  DW  write data driven to the memory.
REQ-015 DataOut  input  DW  combinational read data from the memory; valid only while ReadMem=1.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, READ, WRITE and FIN.
REQ-017 In IDLE with Start=1 and Len!=0, the block SHALL capture Src, Dst and Len, clear index i to 0, and go to READ.
REQ-018 In IDLE with Start=1 and Len=0, the block SHALL go to FIN with no memory access.
REQ-019 In READ, the block SHALL drive DataAddress=(Src+i) mod 2^AW and ReadMem=1, hold WriteMem=0, latch DataOut into the byte buffer at the clock edge, and go to WRITE.
REQ-020 In WRITE, the block SHALL drive DataAddress=(Dst+i) mod 2^AW, WriteMem=1 and DataIn=buffer, and hold ReadMem=0.
REQ-021 At the WRITE edge, the block SHALL increment i; if the incremented i equals Len it SHALL go to FIN, otherwise to READ.
REQ-022 In FIN, the block SHALL assert Done=1 for exactly one cycle and then return to IDLE.
REQ-023 Busy SHALL be 1 in READ, WRITE and FIN, and 0 in IDLE.
REQ-024 ReadMem and WriteMem SHALL never both be 1, and SHALL both be 0 in IDLE and FIN.
REQ-025 DataAddress and DataIn SHALL be 0 whenever neither enable is asserted.
REQ-026 Timing: with Start sampled at edge k, the first read SHALL occur in cycle k+1 and Done SHALL be high in cycle k+2*Len+1 (k+1 when Len=0).
REQ-027 Throughput SHALL be one byte per 2 cycles.
REQ-028 Address arithmetic SHALL wrap modulo 2^AW for both source and destination (e.g. Src=0xFF followed by 0x00).
REQ-029 Copy order SHALL be ascending index.
REQ-030 For an overlapping range with Dst>Src, the block SHALL read bytes already overwritten; no memmove correction SHALL be made.
REQ-031 Start asserted while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-032 Changes on SrcAddr, DstAddr or Len after capture SHALL have no effect on the copy in progress.
REQ-033 A Start held high in the FIN cycle SHALL be ignored; a Start still high in the following IDLE cycle SHALL begin a new copy.

Reset
REQ-034 While RST_N=0, the block SHALL immediately force: state to IDLE, Busy=0, Done=0, ReadMem=0, WriteMem=0, DataAddress=0, DataIn=0, i=0, and the buffer to 0.
REQ-035 On reset mid-copy, the block SHALL abort the copy with no Done pulse; bytes already written SHALL remain and no further write SHALL occur.
REQ-036 After RST_N deasserts, the block SHALL accept Start on the first rising edge.

Verification
REQ-037 Src=0x10, Dst=0x80, Len=4, mem[0x10..0x13]=AA,BB,CC,DD -> mem[0x80..0x83]=AA,BB,CC,DD; Done high exactly once, 9 cycles after the Start edge; Busy high for 9 cycles.
REQ-038 Src=0xFE, Dst=0x40, Len=3 -> reads 0xFE,0xFF,0x00 in order; writes to 0x40..0x42.
REQ-039 Len=0 with Start -> Done pulse in the next cycle; ReadMem and WriteMem stay 0 throughout.
REQ-040 Start pulsed again in the second READ of a Len=4 copy -> ignored; exactly one Done; only 4 writes.
REQ-041 RST_N low during the WRITE of byte 2 of Len=5 -> outputs go to 0 immediately; bytes 0-1 are written; no write to byte 2 or later; no Done.
REQ-042 Every cycle of every test -> the assertion !(ReadMem && WriteMem) holds, and DataAddress==0 whenever both enables are 0.
